uart_axi_lite: RTL and testbench
================================

Name: uart_axi_lite

Overview:
- AXI4-Lite slave UART controller; the UART endpoint behind the MMU's uart_axi_* port (4-bit address space).
- Register map: 0x0 RX data, 0x4 TX data, 0x8 status, 0xC control.
- Serial format is 8N1, LSB first.
- Has one TX FIFO and one RX FIFO between the AXI registers and the serializer/deserializer.

Parameters:
- CLK_PER_BIT, 868, clk cycles per serial bit; minimum 4.
- FIFO_DEPTH, 16, entries per FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- axi_araddr  in  4  read address.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_arprot  in  3  ignored.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response; always 2'b00.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.
- axi_awaddr  in  4  write address.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address ready.
- axi_awprot  in  3  ignored.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  ignored.
- axi_wvalid  in  1  write data valid.
- axi_wready  out  1  write data ready.
- axi_bresp  out  2  write response; always 2'b00.
- axi_bvalid  out  1  write response valid.
- axi_bready  in  1  write response ready.
- rxd  in  1  serial input; asynchronous.
- txd  out  1  serial output; idle high.

Behaviour:
- Reset values: arready=1, awready=1, wready=1; rvalid=0, bvalid=0; rdata=0, rresp=0, bresp=0; txd=1.
- Reset also empties both FIFOs, clears error flags, sets TX/RX FSMs to IDLE and clears intr_en. Reset mid-frame aborts the frame; txd returns to 1 on the next cycle.
- Only address bits [3:2] are decoded.
- Read channel:
  - Handshake at arvalid&arready: arready<=0; next cycle rvalid<=1 with rdata valid.
  - rvalid holds until rready; on that cycle rvalid<=0 and arready<=1.
  - Minimum read: 2 cycles from handshake to accept.
- Write channel:
  - aw and w are accepted independently, each dropping its ready on handshake.
  - Once both are captured, the register action is performed and bvalid<=1 the same cycle.
  - On bvalid&bready: bvalid<=0, awready<=1, wready<=1.
- Register 0x0 (read): {24'b0, rx_head}; pops the RX FIFO. If the RX FIFO is empty, returns 0 and does not pop. Writes are ignored.
- Register 0x4 (write): pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and bresp is still OKAY. Reads return 0.
- Register 0x8 (read) status bits:
  - bit0 rx_valid
  - bit1 rx_full
  - bit2 tx_empty
  - bit3 tx_full
  - bit4 intr_en
  - bit5 overrun
  - bit7 frame_err
  - A status read clears bits 5 and 7 after capture. An error arriving in the same cycle as the clear wins (flag stays set).
- Register 0xC (write) control bits:
  - bit0 resets the TX FIFO; does not abort a byte already in the shifter.
  - bit1 resets the RX FIFO.
  - bit4 sets intr_en.
  - Reads return 0.
- FIFOs: circular, log2(FIFO_DEPTH)+1-bit pointers, wrap at depth. Simultaneous push and pop on a full FIFO: the pop succeeds and the push is dropped.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with TX FIFO non-empty: pop byte, txd=0, go to START.
  - Each state lasts CLK_PER_BIT cycles; DATA lasts 8 bits, LSB first; STOP drives txd=1 for one bit.
  - After STOP, go to IDLE; a queued byte starts on the next cycle with no extra idle bit.
- RX FSM, states IDLE, START, DATA, STOP:
  - rxd passes through a 2-flop synchronizer.
  - IDLE: a falling edge enters START.
  - START: sample at CLK_PER_BIT/2; if high, treat as a glitch and return to IDLE; otherwise go to DATA.
  - DATA: sample 8 bits at CLK_PER_BIT intervals.
  - STOP: sample the stop bit. If 0, set frame_err and discard the byte. Else, if the RX FIFO is full, set overrun and drop the byte; else push the byte.
  - After STOP, go to IDLE.

Optional Feature:
- Macro UART_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0). irq is a one-cycle pulse when intr_en=1 and either rx_valid rises or tx_empty rises.
- Undefined: no irq port; bit4 still reads back intr_en and has no other effect.

Test Plan:
- Reset, then read 0x8 -> rdata=0x00000004; txd=1; arready=1 after rready.
- With CLK_PER_BIT=4, write 0x4 wdata=0xA5 -> txd shows 0, then 1,0,1,0,0,1,0,1, then 1; each bit lasts 4 cycles; then status bit2=1.
- Drive serial 0x3C on rxd, then read 0x0 -> 0x0000003C; next read of 0x8 -> bit0=0.
- Drive serial 0x55 with stop bit 0 -> 0x8 reads bit7=1 and bit0=0; a second 0x8 read shows bit7=0.
- Receive FIFO_DEPTH+1 bytes without reading -> 0x8 shows bit1=1 and bit5=1; the first FIFO_DEPTH bytes read back in order.
- Present aw two cycles before w -> awready=0 while wready=1; bvalid asserts the cycle w is captured; holding bready=0 for 3 cycles keeps bvalid=1 and both readies at 0.

Source files
------------

// File: rtl/uart_axi_lite_if.sv
// AXI4-Lite bus bundle (4-bit address space) for the UART register slave.
// The master modport is the bus initiator side; the slave modport is the UART side.
interface uart_axi_lite_if;
    logic [3:0]  axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [3:0]  axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport master (
        output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/uart_axi_lite.sv
// AXI4-Lite UART (8N1, LSB first) with TX/RX FIFOs. Register map: 0x0 RX, 0x4 TX, 0x8 status, 0xC control.
// Optional macro UART_IRQ_EN adds an irq pulse output on rx_valid / tx_empty rising while intr_en is set.
module uart_axi_lite #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_axi_lite_if.slave s_axi,
    input  logic           rxd,
    output logic           txd
`ifdef UART_IRQ_EN
    ,
    output logic           irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // ---------------- FIFOs ----------------
    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic        w_tx_push, w_tx_pop, w_tx_clr, w_rx_push, w_rx_pop, w_rx_clr;
    logic [7:0]  w_tx_head, w_rx_head;

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
    assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];

    // ---------------- AXI write channel ----------------
    logic       r_awready, r_wready, r_bvalid;
    logic [1:0] r_wr_sel;
    logic [7:0] r_wr_byte;
    logic       w_aw_hs, w_w_hs, w_wr_fire;
    logic [1:0] w_wr_sel;
    logic [7:0] w_wr_byte;

    assign w_aw_hs   = s_axi.axi_awvalid & r_awready;
    assign w_w_hs    = s_axi.axi_wvalid & r_wready;
    // A channel with ready low and no pending response has already been captured.
    assign w_wr_fire = (w_aw_hs | (~r_awready & ~r_bvalid)) & (w_w_hs | (~r_wready & ~r_bvalid));
    assign w_wr_sel  = w_aw_hs ? s_axi.axi_awaddr[3:2] : r_wr_sel;
    assign w_wr_byte = w_w_hs ? s_axi.axi_wdata[7:0] : r_wr_byte;
    assign w_tx_clr  = w_wr_fire & (w_wr_sel == 2'd3) & w_wr_byte[0];
    assign w_rx_clr  = w_wr_fire & (w_wr_sel == 2'd3) & w_wr_byte[1];
    assign w_tx_push = w_wr_fire & (w_wr_sel == 2'd1) & ~w_tx_full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_wr_sel  <= 2'd0;
            r_wr_byte <= 8'd0;
        end else begin
            if (w_aw_hs) begin
                r_awready <= 1'b0;
                r_wr_sel  <= s_axi.axi_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_wready  <= 1'b0;
                r_wr_byte <= s_axi.axi_wdata[7:0];
            end
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            if (r_bvalid & s_axi.axi_bready) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    // ---------------- AXI read channel and status ----------------
    logic        r_arready, r_rvalid, r_rd_pend, r_intr_en, r_overrun, r_frame_err;
    logic [1:0]  r_rd_sel;
    logic [31:0] r_rdata, w_rd_data;
    logic [7:0]  w_status;
    logic        w_ar_hs, w_stat_clr, w_ovr_set, w_ferr_set;

    assign w_ar_hs    = s_axi.axi_arvalid & r_arready;
    assign w_rx_pop   = r_rd_pend & (r_rd_sel == 2'd0) & ~w_rx_empty;
    assign w_stat_clr = r_rd_pend & (r_rd_sel == 2'd2);
    assign w_status   = {r_frame_err, 1'b0, r_overrun, r_intr_en,
                         w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

    always_comb begin
        w_rd_data = 32'd0;
        case (r_rd_sel)
            2'd0:    w_rd_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
            2'd2:    w_rd_data = {24'd0, w_status};
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_arready   <= 1'b1;
            r_rvalid    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_sel    <= 2'd0;
            r_rdata     <= 32'd0;
            r_intr_en   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arready <= 1'b0;
                r_rd_pend <= 1'b1;
                r_rd_sel  <= s_axi.axi_araddr[3:2];
            end
            if (r_rd_pend) begin
                r_rd_pend <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_data;
            end
            if (r_rvalid & s_axi.axi_rready) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end
            // intr_en is set-only; it is cleared solely by reset.
            if (w_wr_fire && w_wr_sel == 2'd3 && w_wr_byte[4])
                r_intr_en <= 1'b1;
            // A new error in the clearing cycle keeps the flag set.
            if (w_ovr_set)       r_overrun <= 1'b1;
            else if (w_stat_clr) r_overrun <= 1'b0;
            if (w_ferr_set)      r_frame_err <= 1'b1;
            else if (w_stat_clr) r_frame_err <= 1'b0;
        end
    end

    // ---------------- FIFO pointers and storage ----------------
    always_ff @(posedge clk) begin
        if (!rstn || w_tx_clr) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + (AW+1)'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || w_rx_clr) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + (AW+1)'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + (AW+1)'(1);
        end
    end

    logic [7:0] r_rx_shift;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= w_wr_byte;
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
    end

    // ---------------- TX serializer ----------------
    state_t         r_tx_state, w_tx_state_next;
    logic [CW-1:0]  r_tx_cnt, w_tx_cnt_next;
    logic [2:0]     r_tx_bit, w_tx_bit_next;
    logic [7:0]     r_tx_shift, w_tx_shift_next;
    logic           r_txd, w_txd_next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_txd      <= w_txd_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + CW'(1);
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_txd_next      = r_txd;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_next = '0;
                if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_head;
                    w_txd_next      = 1'b0;
                    w_tx_state_next = ST_START;
                end
            end
            ST_START: if (r_tx_cnt == LAST) begin
                w_tx_cnt_next   = '0;
                w_tx_bit_next   = 3'd0;
                w_txd_next      = r_tx_shift[0];
                w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                w_tx_state_next = ST_DATA;
            end
            ST_DATA: if (r_tx_cnt == LAST) begin
                w_tx_cnt_next = '0;
                if (r_tx_bit == 3'd7) begin
                    w_txd_next      = 1'b1;
                    w_tx_state_next = ST_STOP;
                end else begin
                    w_tx_bit_next   = r_tx_bit + 3'd1;
                    w_txd_next      = r_tx_shift[0];
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                end
            end
            ST_STOP: if (r_tx_cnt == LAST) begin
                w_tx_cnt_next   = '0;
                w_tx_state_next = ST_IDLE;
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
    end

    assign txd = r_txd;

    // ---------------- RX deserializer ----------------
    state_t         r_rx_state, w_rx_state_next;
    logic [CW-1:0]  r_rx_cnt, w_rx_cnt_next;
    logic [2:0]     r_rx_bit, w_rx_bit_next;
    logic [7:0]     w_rx_shift_next;
    logic           r_rx_s1, r_rx_s2, r_rx_prev;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + CW'(1);
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_push       = 1'b0;
        w_ovr_set       = 1'b0;
        w_ferr_set      = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_next = '0;
                if (r_rx_prev && !r_rx_s2)
                    w_rx_state_next = ST_START;
            end
            // Mid-start-bit check; a high line here was a glitch.
            ST_START: if (r_rx_cnt == HALF) begin
                w_rx_cnt_next   = '0;
                w_rx_bit_next   = 3'd0;
                w_rx_state_next = r_rx_s2 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (r_rx_cnt == LAST) begin
                w_rx_cnt_next   = '0;
                w_rx_shift_next = {r_rx_s2, r_rx_shift[7:1]};
                if (r_rx_bit == 3'd7) w_rx_state_next = ST_STOP;
                else                  w_rx_bit_next   = r_rx_bit + 3'd1;
            end
            ST_STOP: if (r_rx_cnt == LAST) begin
                w_rx_cnt_next   = '0;
                w_rx_state_next = ST_IDLE;
                if (!r_rx_s2)       w_ferr_set = 1'b1;
                else if (w_rx_full) w_ovr_set  = 1'b1;
                else                w_rx_push  = ~w_rx_clr;
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

`ifdef UART_IRQ_EN
    logic r_rx_valid_d, r_tx_empty_d, r_irq;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_valid_d <= 1'b0;
            r_tx_empty_d <= 1'b1;
            r_irq        <= 1'b0;
        end else begin
            r_rx_valid_d <= ~w_rx_empty;
            r_tx_empty_d <= w_tx_empty;
            r_irq        <= r_intr_en & ((~w_rx_empty & ~r_rx_valid_d) | (w_tx_empty & ~r_tx_empty_d));
        end
    end

    assign irq = r_irq;
`endif

    assign s_axi.axi_arready = r_arready;
    assign s_axi.axi_rdata   = r_rdata;
    assign s_axi.axi_rresp   = 2'b00;
    assign s_axi.axi_rvalid  = r_rvalid;
    assign s_axi.axi_awready = r_awready;
    assign s_axi.axi_wready  = r_wready;
    assign s_axi.axi_bresp   = 2'b00;
    assign s_axi.axi_bvalid  = r_bvalid;

    logic w_unused;
    assign w_unused = &{1'b0, s_axi.axi_arprot, s_axi.axi_awprot, s_axi.axi_wstrb,
                        s_axi.axi_wdata[31:8], s_axi.axi_araddr[1:0], s_axi.axi_awaddr[1:0]};
endmodule

// File: tb/tb_uart_axi_lite.sv
// Directed self-checking bench for uart_axi_lite with CLK_PER_BIT=4 and FIFO_DEPTH=4.
// Exercises reset state, TX framing, RX data, frame error, overrun and split AW/W writes.
module tb_uart_axi_lite;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    logic rxd;
    logic txd;
`ifdef UART_IRQ_EN
    logic irq;
`endif

    int n_total = 0;
    int n_bad   = 0;

    uart_axi_lite_if bus ();

    uart_axi_lite #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .s_axi (bus),
        .rxd   (rxd),
        .txd   (txd)
`ifdef UART_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        n_total++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        data = 32'hDEAD_BEEF;
        bus.axi_araddr  = addr;
        bus.axi_arvalid = 1'b1;
        bus.axi_rready  = 1'b1;
        t = 0;
        while (bus.axi_arready !== 1'b1 && t < 50) begin step(); t++; end
        step();
        bus.axi_arvalid = 1'b0;
        t = 0;
        while (bus.axi_rvalid !== 1'b1 && t < 50) begin step(); t++; end
        if (t >= 50) tmo("rd_rvalid");
        else data = bus.axi_rdata;
        step();
        bus.axi_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
        int t;
        logic a_done, w_done, a_rdy, w_rdy;
        bus.axi_awaddr  = addr;
        bus.axi_wdata   = data;
        bus.axi_awvalid = 1'b1;
        bus.axi_wvalid  = 1'b1;
        bus.axi_bready  = 1'b1;
        a_done = 1'b0;
        w_done = 1'b0;
        t = 0;
        while (!(a_done && w_done) && t < 50) begin
            a_rdy = bus.axi_awready;
            w_rdy = bus.axi_wready;
            step();
            if (a_rdy && bus.axi_awvalid) begin a_done = 1'b1; bus.axi_awvalid = 1'b0; end
            if (w_rdy && bus.axi_wvalid)  begin w_done = 1'b1; bus.axi_wvalid  = 1'b0; end
            t++;
        end
        t = 0;
        while (bus.axi_bvalid !== 1'b1 && t < 50) begin step(); t++; end
        if (t >= 50) tmo("wr_bvalid");
        step();
        bus.axi_bready = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (CPB) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
    endtask

    // Start bit, 0xA5 LSB first, stop bit; every bit must hold for CPB cycles.
    task automatic tx_monitor();
        int t;
        logic [3:0] obs;
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        t = 0;
        while (txd !== 1'b0 && t < 200) begin step(); t++; end
        if (t >= 200) tmo("tx_start");
        else begin
            for (int i = 0; i < 10; i++) begin
                for (int c = 0; c < CPB; c++) begin
                    obs[c] = txd;
                    step();
                end
                check($sformatf("tx_bit%0d", i), 32'(obs), exp_bits[i] ? 32'hF : 32'h0);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  rx_bytes [5];
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
        rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;

        rstn = 1'b0;
        rxd  = 1'b1;
        bus.axi_araddr  = 4'h0; bus.axi_arvalid = 1'b0; bus.axi_arprot = 3'd0;
        bus.axi_rready  = 1'b0;
        bus.axi_awaddr  = 4'h0; bus.axi_awvalid = 1'b0; bus.axi_awprot = 3'd0;
        bus.axi_wdata   = 32'd0; bus.axi_wstrb  = 4'hF; bus.axi_wvalid  = 1'b0;
        bus.axi_bready  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();

        // Reset state
        check("rst_arready", 32'(bus.axi_arready), 32'd1);
        check("rst_awready", 32'(bus.axi_awready), 32'd1);
        check("rst_wready",  32'(bus.axi_wready),  32'd1);
        check("rst_rvalid",  32'(bus.axi_rvalid),  32'd0);
        check("rst_bvalid",  32'(bus.axi_bvalid),  32'd0);
        check("rst_rdata",   bus.axi_rdata,        32'd0);
        check("rst_txd",     32'(txd),             32'd1);

        axi_read(4'h8, rd);
        check("status_reset", rd, 32'h0000_0004);
        check("arready_after_rready", 32'(bus.axi_arready), 32'd1);
        check("rresp_okay", 32'(bus.axi_rresp), 32'd0);

        // TX 0xA5
        fork
            axi_write(4'h4, 32'h0000_00A5);
            tx_monitor();
        join
        check("bresp_okay", 32'(bus.axi_bresp), 32'd0);
        axi_read(4'h8, rd);
        check("status_tx_done", rd, 32'h0000_0004);

        // RX 0x3C
        send_byte(8'h3C, 1'b1);
        axi_read(4'h0, rd);
        check("rx_data_3c", rd, 32'h0000_003C);
        axi_read(4'h8, rd);
        check("status_rx_drained", rd, 32'h0000_0004);
        axi_read(4'h0, rd);
        check("rx_empty_read", rd, 32'h0000_0000);

        // Frame error
        send_byte(8'h55, 1'b0);
        axi_read(4'h8, rd);
        check("status_frame_err", rd, 32'h0000_0084);
        axi_read(4'h8, rd);
        check("status_ferr_cleared", rd, 32'h0000_0004);

        // Overrun: DEPTH+1 bytes
        for (int i = 0; i < DEPTH + 1; i++) send_byte(rx_bytes[i], 1'b1);
        axi_read(4'h8, rd);
        check("status_overrun", rd, 32'h0000_0027);
        for (int i = 0; i < DEPTH; i++) begin
            axi_read(4'h0, rd);
            check($sformatf("rx_order%0d", i), rd, {24'd0, rx_bytes[i]});
        end
        axi_read(4'h8, rd);
        check("status_after_drain", rd, 32'h0000_0004);

        // AW two cycles ahead of W, B held off for three cycles
        bus.axi_awaddr  = 4'h0;
        bus.axi_wdata   = 32'd0;
        bus.axi_bready  = 1'b0;
        bus.axi_awvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0;
        check("split_awready", 32'(bus.axi_awready), 32'd0);
        check("split_wready",  32'(bus.axi_wready),  32'd1);
        step();
        check("split_bvalid_early", 32'(bus.axi_bvalid), 32'd0);
        bus.axi_wvalid = 1'b1;
        step();
        bus.axi_wvalid = 1'b0;
        check("split_bvalid_on_w", 32'(bus.axi_bvalid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_bvalid%0d", i),
                  {29'd0, bus.axi_bvalid, bus.axi_awready, bus.axi_wready}, 32'h4);
            step();
        end
        bus.axi_bready = 1'b1;
        step();
        bus.axi_bready = 1'b0;
        check("b_done_readies",
              {29'd0, bus.axi_bvalid, bus.axi_awready, bus.axi_wready}, 32'h3);

        // Control: intr_en reads back in status
        axi_write(4'hC, 32'h0000_0010);
        axi_read(4'h8, rd);
        check("status_intr_en", rd, 32'h0000_0014);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
